// File: rtl/div_clk_meter_pkg.sv
// ============================================================================
// Module      : div_meter_pkg
// Description : Shared types and defaults for the divided-clock meter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package div_meter_pkg;

   localparam int DEF_CNT_W    = 8;
   localparam int DEF_LOCK_CNT = 4;
   localparam int DEF_TIMEOUT  = 255;
   localparam int MATCH_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      MEAS = 2'd2
   } meas_state_e;

endpackage

`default_nettype wire

// File: rtl/div_clk_meter_if.sv
// ============================================================================
// Module      : div_clk_meter_if
// Description : Measurement result bundle produced by div_clk_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface div_clk_meter_if
   import div_meter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             timeout;

   modport master (
      output period, high_time, meas_valid, locked, timeout
   );

   modport slave (
      input  period, high_time, meas_valid, locked, timeout
   );
endinterface

`default_nettype wire

// File: rtl/div_clk_meter_sync_rise_det.sv
// ============================================================================
// Module      : sync_rise_det
// Description : Two-flop synchronizer with history flop and rising-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_rise_det (
   input  wire logic clk_in,
   input  wire logic rst_n,
   input  wire logic async_in,
   output logic      s2,
   output logic      rise
);
   logic s1_q, s2_q, s3_q;
   logic s1_d, s2_d, s3_d;

   always_comb begin
      s1_d = async_in;
      s2_d = s1_q;
      s3_d = s2_q;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         s3_q <= s3_d;
      end
   end

   assign s2   = s2_q;
   assign rise = s2_q & ~s3_q;

endmodule

`default_nettype wire

// File: rtl/div_clk_meter.sv
// ============================================================================
// Module      : div_clk_meter
// Description : Measures period/high time of an async divided clock, with lock.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module div_clk_meter
   import div_meter_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int LOCK_CNT = DEF_LOCK_CNT,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  wire logic         clk_in,
   input  wire logic         rst_n,
   input  wire logic         div_clk,
   div_clk_meter_if.master   meas
);
   localparam logic [CNT_W-1:0]   TO_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [MATCH_W-1:0] LOCK_M  = MATCH_W'(LOCK_CNT);

   logic s2, rise;

   sync_rise_det u_sync (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .async_in (div_clk),
      .s2       (s2),
      .rise     (rise)
   );

   meas_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   hcnt_q, hcnt_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   high_q, high_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic               valid_q, valid_d;
   logic               locked_q, locked_d;
   logic               timeout_q, timeout_d;

   logic [CNT_W-1:0]   period_new;
   logic [MATCH_W-1:0] match_inc;

   // cnt holds cycles since the last rise minus one, hence the +1.
   assign period_new = cnt_q + 1'b1;
   assign match_inc  = (match_q == LOCK_M) ? match_q : match_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      period_d  = period_q;
      high_d    = high_q;
      match_d   = match_q;
      valid_d   = 1'b0;
      locked_d  = locked_q;
      timeout_d = timeout_q;

      if (rise) begin
         cnt_d     = '0;
         hcnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
         timeout_d = 1'b0;
      end else begin
         if (cnt_q != TO_MAX) cnt_d = cnt_q + 1'b1;
         if (s2 && (hcnt_q != '1)) hcnt_d = hcnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            // The partial period before the first rise is never published.
            if (rise) state_d = ARM;
         end
         ARM: begin
            if (rise) begin
               state_d  = MEAS;
               period_d = period_new;
               high_d   = hcnt_q;
               valid_d  = 1'b1;
               match_d  = {{(MATCH_W-1){1'b0}}, 1'b1};
               locked_d = 1'b0;
            end else if (cnt_q == TO_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               locked_d  = 1'b0;
               match_d   = '0;
            end
         end
         MEAS: begin
            if (rise) begin
               period_d = period_new;
               high_d   = hcnt_q;
               valid_d  = 1'b1;
               if (period_new == period_q) begin
                  match_d  = match_inc;
                  locked_d = (match_inc == LOCK_M);
               end else begin
                  match_d  = {{(MATCH_W-1){1'b0}}, 1'b1};
                  locked_d = 1'b0;
               end
            end else if (cnt_q == TO_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               locked_d  = 1'b0;
               match_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         match_q   <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         period_q  <= period_d;
         high_q    <= high_d;
         match_q   <= match_d;
         valid_q   <= valid_d;
         locked_q  <= locked_d;
         timeout_q <= timeout_d;
      end
   end

   assign meas.period     = period_q;
   assign meas.high_time  = high_q;
   assign meas.meas_valid = valid_q;
   assign meas.locked     = locked_q;
   assign meas.timeout    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_div_clk_meter.sv
// ============================================================================
// Module      : tb_div_clk_meter
// Description : Directed vector bench for div_clk_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_clk_meter;
   localparam int CNT_W    = 8;
   localparam int LOCK_CNT = 4;
   localparam int TIMEOUT  = 255;

   logic clk_in  = 1'b0;
   logic rst_n   = 1'b0;
   logic div_clk = 1'b0;

   div_clk_meter_if #(.CNT_W(CNT_W)) mif ();

   div_clk_meter #(
      .CNT_W    (CNT_W),
      .LOCK_CNT (LOCK_CNT),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .div_clk (div_clk),
      .meas    (mif)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   initial forever begin
      @(posedge clk_in);
      cyc++;
   end

   // Half-cycle pattern generator: gen_hp half-slots per period, first gen_high are high.
   int gen_hp = 10, gen_high = 4, nxt_hp = 10, nxt_high = 4, phase = 0;
   bit gen_run = 1'b0, gen_lvl = 1'b0, sw_pend = 1'b0;

   initial forever begin
      @(clk_in);
      #1;
      if (!gen_run) begin
         div_clk = gen_lvl;
         phase   = 0;
      end else begin
         if (phase == 0 && sw_pend) begin
            gen_hp   = nxt_hp;
            gen_high = nxt_high;
            sw_pend  = 1'b0;
         end
         div_clk = (phase < gen_high);
         phase   = (phase + 1) % gen_hp;
      end
   end

   initial begin
      #900us;
      $display("FAIL watchdog: got time limit expired, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   task automatic wait_meas(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (mif.meas_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("meas_wait_expired", 0, 1);
   endtask

   task automatic do_reset();
      gen_run = 1'b0;
      gen_lvl = 1'b0;
      @(negedge clk_in);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      check("rst_period", int'(mif.period), 0);
      check("rst_valid_lock_to", {mif.meas_valid, mif.locked, mif.timeout}, 0);
      #2 rst_n = 1'b1;
   endtask

   task automatic set_gen(input int hp, input int high);
      @(negedge clk_in);
      phase    = 0;
      gen_hp   = hp;
      gen_high = high;
      sw_pend  = 1'b0;
      gen_run  = 1'b1;
   endtask

   typedef struct {
      int hp;
      int high;
      int n;
      int exp_p;
      int h_lo;
      int h_hi;
   } vec_t;

   vec_t vecs[6];

   initial begin
      bit ok;
      int h, first_h, last_c, n, c0, rel;
      bit early;

      vecs[0] = '{hp: 6,   high: 3,   n: 5, exp_p: 3,   h_lo: 1,   h_hi: 2};
      vecs[1] = '{hp: 12,  high: 6,   n: 5, exp_p: 6,   h_lo: 3,   h_hi: 3};
      vecs[2] = '{hp: 4,   high: 2,   n: 5, exp_p: 2,   h_lo: 1,   h_hi: 1};
      vecs[3] = '{hp: 10,  high: 4,   n: 5, exp_p: 5,   h_lo: 2,   h_hi: 2};
      vecs[4] = '{hp: 14,  high: 7,   n: 5, exp_p: 7,   h_lo: 3,   h_hi: 4};
      vecs[5] = '{hp: 508, high: 254, n: 4, exp_p: 254, h_lo: 127, h_hi: 127};

      repeat (2) @(negedge clk_in);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         set_gen(vecs[v].hp, vecs[v].high);
         first_h = 0;
         last_c  = 0;
         for (int k = 0; k < vecs[v].n; k++) begin
            wait_meas(3 * vecs[v].exp_p + 12, ok);
            if (!ok) break;
            h = int'(mif.high_time);
            check($sformatf("v%0d_m%0d_period", v, k), int'(mif.period), vecs[v].exp_p);
            check($sformatf("v%0d_m%0d_high_in_range(h=%0d)", v, k, h),
                  int'(h >= vecs[v].h_lo && h <= vecs[v].h_hi), 1);
            if (k == 0) first_h = h;
            else begin
               check($sformatf("v%0d_m%0d_high_const", v, k), h, first_h);
               check($sformatf("v%0d_m%0d_spacing", v, k), cyc - last_c, vecs[v].exp_p);
            end
            last_c = cyc;
            check($sformatf("v%0d_m%0d_locked", v, k), int'(mif.locked), int'(k >= LOCK_CNT - 1));
            check($sformatf("v%0d_m%0d_timeout", v, k), int'(mif.timeout), 0);
         end
      end

      // Ratio change 5 -> 7 while locked.
      do_reset();
      set_gen(10, 4);
      for (int k = 0; k < 4; k++) wait_meas(30, ok);
      check("sw_locked_before", int'(mif.locked), 1);
      nxt_hp   = 14;
      nxt_high = 6;
      sw_pend  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_meas(40, ok);
         if (!ok || mif.period != 8'd5) break;
         check("sw_old_locked", int'(mif.locked), 1);
      end
      check("sw_first7_period", int'(mif.period), 7);
      check("sw_first7_unlock", int'(mif.locked), 0);
      for (int k = 0; k < 3; k++) begin
         wait_meas(40, ok);
         check($sformatf("sw_7_m%0d_period", k), int'(mif.period), 7);
         check($sformatf("sw_7_m%0d_locked", k), int'(mif.locked), int'(k == 2));
      end

      // Stuck-low after lock: timeout, hold, then rearm.
      do_reset();
      set_gen(10, 4);
      for (int k = 0; k < 4; k++) wait_meas(30, ok);
      check("stk_locked_before", int'(mif.locked), 1);
      gen_run = 1'b0;
      gen_lvl = 1'b0;
      n = 0;
      while (n < TIMEOUT + 10) begin
         @(negedge clk_in);
         n++;
         if (mif.timeout) break;
      end
      check("stk_timeout_delay", n, TIMEOUT);
      check("stk_timeout_flag", int'(mif.timeout), 1);
      check("stk_locked_clear", int'(mif.locked), 0);
      check("stk_period_hold", int'(mif.period), 5);
      check("stk_high_hold", int'(mif.high_time), 2);
      set_gen(10, 4);
      early = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_in);
         if (mif.meas_valid) early = 1'b1;
         if (!mif.timeout) break;
      end
      check("rearm_timeout_cleared", int'(mif.timeout), 0);
      check("rearm_no_early_valid", int'(early), 0);
      c0 = cyc;
      wait_meas(30, ok);
      check("rearm_gap", cyc - c0, 5);
      check("rearm_period", int'(mif.period), 5);

      // Reset pulse mid-period at ratio 9.
      do_reset();
      set_gen(18, 9);
      for (int k = 0; k < 4; k++) wait_meas(40, ok);
      check("rstm_locked_before", int'(mif.locked), 1);
      repeat (3) @(negedge clk_in);
      #2 rst_n = 1'b0;
      #1;
      check("rstm_period", int'(mif.period), 0);
      check("rstm_high", int'(mif.high_time), 0);
      check("rstm_valid_lock_to", {mif.meas_valid, mif.locked, mif.timeout}, 0);
      for (int i = 0; i < 40 && !div_clk; i++) begin @(negedge clk_in); #2; end
      for (int i = 0; i < 40 && div_clk; i++) begin @(negedge clk_in); #2; end
      rst_n = 1'b1;
      rel = cyc;
      wait_meas(40, ok);
      check("rstm_gap_ge_10", int'((cyc - rel) >= 10), 1);
      check("rstm_period_after", int'(mif.period), 9);
      check("rstm_locked_after", int'(mif.locked), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/div_clk_meter.md
Name: div_clk_meter

Overview:
Measures a divided clock produced by the team's odd/even clock dividers. It reports the period and high time in clk_in cycles, and asserts lock when the period is stable. It sits on the receive side of divider outputs, for self-check and for clock-ratio discovery in test logic. The signal under measurement is treated as asynchronous and is synchronized internally.

Parameters:
CNT_W, 8, width of the period/high-time counters and outputs.
LOCK_CNT, 4, number of consecutive identical periods required to assert locked (legal range 2..15).
TIMEOUT, 255, clk_in cycles without a rising edge before timeout is flagged. Must be ≤ 2^CNT_W-1.

Ports:
clk_in  input  1  measurement clock, all logic on its rising edge.
rst_n  input  1  asynchronous active-low reset.
div_clk  input  1  divided clock under measurement, asynchronous.
period  output  CNT_W  last measured period, in clk_in cycles.
high_time  output  CNT_W  clk_in cycles div_clk was sampled high in the last period.
meas_valid  output  1  one-cycle pulse when period/high_time update.
locked  output  1  period stable for LOCK_CNT consecutive measurements.
timeout  output  1  sticky until the next rising edge; no edge seen for TIMEOUT cycles.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, counters 0, synchronizer flops 0, FSM in IDLE.
- Sync path: two flops (s1, s2) plus history flop s3. rise = s2 & ~s3. Input-to-rise latency is 2–3 clk_in cycles.
- cnt rules:
  - Cleared to 0 on a rise cycle.
  - Otherwise increments, saturating at TIMEOUT.
- hcnt rules:
  - Set to 1 on a rise cycle.
  - Otherwise increments when s2=1 (saturating).
- FSM states IDLE, ARM, MEAS.
  - IDLE: wait for rise. On rise go to ARM and clear counters. No meas_valid is produced, because the first partial period is discarded.
  - ARM: on rise, go to MEAS. Publish period=cnt+1 and high_time=hcnt, pulse meas_valid the next cycle (registered), and set match_cnt=1.
  - MEAS: on rise, publish the same way.
    - If the new period equals the previous period, match_cnt increments (saturating at LOCK_CNT).
    - Otherwise match_cnt is set to 1 and locked is cleared in that same cycle.
    - locked=1 when match_cnt reaches LOCK_CNT.
- Timeout (ARM or MEAS, cnt reaches TIMEOUT without a rise):
  - timeout=1, locked=0, match_cnt=0, go to IDLE.
  - period and high_time hold their last values.
  - timeout clears on the next rise.
- Publish timing: meas_valid, period and high_time all change one cycle after the rise cycle.
- Width rule: period is exact for any divider ratio from 2 to TIMEOUT-1.
- high_time is quantized to clk_in posedges: for half-cycle duty (odd-ratio 50% dividers) it reads floor or ceil of the true high time, and is constant for a fixed phase.
- Constant-level div_clk (stuck 0 or 1) always ends in timeout.
- A rise in the same cycle that cnt reaches TIMEOUT: the rise wins. It counts as a valid measurement, with no timeout.
- rst_n assertion mid-measurement aborts immediately. After release the block restarts from IDLE, so the first meas_valid needs two full rising edges.

Decomposition:
- Package div_meter_pkg holds:
  - state enum (IDLE, ARM, MEAS);
  - default CNT_W, LOCK_CNT and TIMEOUT constants;
  - match counter width constant (4).
- One sub-module, sync_rise_det: 2-flop synchronizer plus rise-edge detector, with outputs s2 and rise. It is reusable by other divider-related blocks.

Test Plan:
- Divide-by-3 divider output (50% duty, high 1.5 cycles) -> period=3 on every meas_valid, high_time constant at 1 or 2, locked=1 on the 4th meas_valid, timeout=0.
- Divide-by-6 even divider (high 3) -> period=6, high_time=3, meas_valid every 6 cycles, locked after 4 measurements.
- Ratio switched 5 -> 7 while locked -> the first 7 measurement clears locked in its publish cycle. locked re-asserts on the 4th consecutive 7.
- div_clk held 0 after lock -> timeout=1 exactly TIMEOUT cycles after the last counted rise, locked=0, and period holds 5. The next edges need ARM plus one measurement before meas_valid reappears.
- rst_n pulsed low mid-period at ratio 9 -> all outputs 0 asynchronously. After release there is no meas_valid until the second rise, then period=9.
- Boundary: ratio 2 (toggle every cycle) -> period=2, high_time=1. A period of exactly TIMEOUT-1 -> valid measurement, no timeout.
